// File: rtl/ufi_pkg.sv
// Shared UFI router definitions: default widths, read FSM encoding, error data value.
package ufi_pkg;

  localparam int UFI_BUS_WIDTH    = 32;
  localparam int UFI_ADRS_WIDTH   = 32;
  localparam int UFI_SLAVE_NUM    = 9;
  localparam int UFI_DECODE_LSB   = 28;
  localparam int UFI_DECODE_WIDTH = 4;
  localparam int UFI_TIMEOUT      = 255;

  // Unmapped/timed-out reads return this value replicated across the bus.
  localparam logic UFI_ERR_DATA_BIT = 1'b0;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_WAIT = 2'd1,
    RD_RESP = 2'd2
  } rd_state_e;

endpackage

// File: rtl/ufi_adrs_decode.sv
// Address to one-hot slave select; slave-select values at or above pSlaveNum are unmapped.
module ufi_adrs_decode
  import ufi_pkg::*;
#(
  parameter int pAdrsWidth   = UFI_ADRS_WIDTH,
  parameter int pSlaveNum    = UFI_SLAVE_NUM,
  parameter int pDecodeLsb   = UFI_DECODE_LSB,
  parameter int pDecodeWidth = UFI_DECODE_WIDTH
) (
  input  logic [pAdrsWidth-1:0] adrs,
  output logic [pSlaveNum-1:0]  onehot,
  output logic                  mapped
);

  localparam logic [pDecodeWidth:0] SLV_NUM = pSlaveNum[pDecodeWidth:0];

  logic [pDecodeWidth-1:0] sel;
  logic                    unused_adrs;

  assign sel         = adrs[pDecodeLsb +: pDecodeWidth];
  assign unused_adrs = ^adrs;
  assign mapped      = ({1'b0, sel} < SLV_NUM);

  // No slave index matches an unmapped select, so onehot is zero then.
  always_comb begin
    onehot = '0;
    for (int n = 0; n < pSlaveNum; n++)
      onehot[n] = (sel == n[pDecodeWidth-1:0]);
  end

endmodule

// File: rtl/slave_ufi_router.sv
// UFI master-to-N-slave router: registered write fan-out plus IDLE/WAIT/RESP read FSM.
// Optional read timeout in WAIT enabled by defining UFI_ROUTER_TIMEOUT_EN.
module slave_ufi_router
  import ufi_pkg::*;
#(
  parameter int pUfiBusWidth   = UFI_BUS_WIDTH,
  parameter int pUfiAdrsWidth  = UFI_ADRS_WIDTH,
  parameter int pUfiSlaveNum   = UFI_SLAVE_NUM,
  parameter int pDecodeLsb     = UFI_DECODE_LSB,
  parameter int pDecodeWidth   = UFI_DECODE_WIDTH,
  parameter int pTimeoutCycles = UFI_TIMEOUT
) (
  input  logic                                 iCLK,
  input  logic                                 iRST,
  input  logic [pUfiBusWidth-1:0]              iSUfiWd,
  input  logic [pUfiAdrsWidth-1:0]             iSUfiWAdrs,
  input  logic                                 iSUfiWEd,
  input  logic [pUfiAdrsWidth-1:0]             iSUfiRAdrs,
  input  logic                                 iSUfiREd,
  output logic                                 oSUfiRdy,
  output logic [pUfiBusWidth-1:0]              oSUfiRd,
  output logic                                 oSUfiRVd,
  output logic                                 oSUfiErr,
  output logic [pUfiBusWidth-1:0]              oMUfiWd,
  output logic [pUfiAdrsWidth-1:0]             oMUfiWAdrs,
  output logic [pUfiSlaveNum-1:0]              oMUfiWEd,
  output logic [pUfiAdrsWidth-1:0]             oMUfiRAdrs,
  output logic [pUfiSlaveNum-1:0]              oMUfiREd,
  input  logic [pUfiSlaveNum*pUfiBusWidth-1:0] iMUfiRd,
  input  logic [pUfiSlaveNum-1:0]              iMUfiRVd
);

  localparam logic [pUfiBusWidth-1:0] ERR_DATA = {pUfiBusWidth{UFI_ERR_DATA_BIT}};

  logic [pUfiSlaveNum-1:0] w_oh, r_oh, sel_oh;
  logic                    w_mapped, r_mapped, rd_hit;
  logic [pUfiBusWidth-1:0] rd_mux;
  rd_state_e               state;

  ufi_adrs_decode #(.pAdrsWidth(pUfiAdrsWidth), .pSlaveNum(pUfiSlaveNum),
                    .pDecodeLsb(pDecodeLsb), .pDecodeWidth(pDecodeWidth))
  u_wdec (.adrs(iSUfiWAdrs), .onehot(w_oh), .mapped(w_mapped));

  ufi_adrs_decode #(.pAdrsWidth(pUfiAdrsWidth), .pSlaveNum(pUfiSlaveNum),
                    .pDecodeLsb(pDecodeLsb), .pDecodeWidth(pDecodeWidth))
  u_rdec (.adrs(iSUfiRAdrs), .onehot(r_oh), .mapped(r_mapped));

  // Write path never stalls; unmapped writes leave every enable low.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      oMUfiWd    <= '0;
      oMUfiWAdrs <= '0;
      oMUfiWEd   <= '0;
    end else begin
      oMUfiWd    <= iSUfiWd;
      oMUfiWAdrs <= iSUfiWAdrs;
      oMUfiWEd   <= (iSUfiWEd && w_mapped) ? w_oh : '0;
    end
  end

  // Latched select is kept one-hot so only the addressed slave's valid/data are seen.
  always_comb begin
    rd_mux = '0;
    for (int n = 0; n < pUfiSlaveNum; n++)
      if (sel_oh[n]) rd_mux = rd_mux | iMUfiRd[n*pUfiBusWidth +: pUfiBusWidth];
  end
  assign rd_hit = |(iMUfiRVd & sel_oh);

`ifdef UFI_ROUTER_TIMEOUT_EN
  localparam int CW = $clog2(pTimeoutCycles + 1);
  logic [CW-1:0] to_cnt;
  logic          to_hit;
  assign to_hit = (to_cnt == CW'(pTimeoutCycles - 1));
`else
  localparam int unused_timeout = pTimeoutCycles;
`endif

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state      <= RD_IDLE;
      oSUfiRdy   <= 1'b1;
      oSUfiRVd   <= 1'b0;
      oSUfiErr   <= 1'b0;
      oSUfiRd    <= '0;
      oMUfiREd   <= '0;
      oMUfiRAdrs <= '0;
      sel_oh     <= '0;
`ifdef UFI_ROUTER_TIMEOUT_EN
      to_cnt     <= '0;
`endif
    end else begin
      oMUfiREd <= '0;
      oSUfiRVd <= 1'b0;
      case (state)
        RD_IDLE: if (iSUfiREd) begin
          oSUfiRdy <= 1'b0;
          if (r_mapped) begin
            oMUfiRAdrs <= iSUfiRAdrs;
            oMUfiREd   <= r_oh;
            sel_oh     <= r_oh;
            state      <= RD_WAIT;
`ifdef UFI_ROUTER_TIMEOUT_EN
            to_cnt     <= '0;
`endif
          end else begin
            oSUfiRd  <= ERR_DATA;
            oSUfiErr <= 1'b1;
            oSUfiRVd <= 1'b1;
            state    <= RD_RESP;
          end
        end
        RD_WAIT: begin
          if (rd_hit) begin
            oSUfiRd  <= rd_mux;
            oSUfiErr <= 1'b0;
            oSUfiRVd <= 1'b1;
            state    <= RD_RESP;
          end
`ifdef UFI_ROUTER_TIMEOUT_EN
          else if (to_hit) begin
            oSUfiRd  <= ERR_DATA;
            oSUfiErr <= 1'b1;
            oSUfiRVd <= 1'b1;
            state    <= RD_RESP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        RD_RESP: begin
          oSUfiErr <= 1'b0;
          oSUfiRdy <= 1'b1;
          state    <= RD_IDLE;
        end
        default: state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slave_ufi_router.sv
// Bench for slave_ufi_router: write/read vector tables, slave latency model, response scoreboard.
module tb_slave_ufi_router;
  localparam int W = 32, A = 32, N = 9, DL = 28, DW = 4, TO = 8;

  logic           iCLK = 1'b0, iRST = 1'b0;
  logic [W-1:0]   iSUfiWd = '0;
  logic [A-1:0]   iSUfiWAdrs = '0, iSUfiRAdrs = '0;
  logic           iSUfiWEd = 1'b0, iSUfiREd = 1'b0;
  logic           oSUfiRdy, oSUfiRVd, oSUfiErr;
  logic [W-1:0]   oSUfiRd, oMUfiWd;
  logic [A-1:0]   oMUfiWAdrs, oMUfiRAdrs;
  logic [N-1:0]   oMUfiWEd, oMUfiREd;
  logic [N*W-1:0] iMUfiRd = '0;
  logic [N-1:0]   iMUfiRVd = '0;

  always #5 iCLK = ~iCLK;

  slave_ufi_router #(.pUfiBusWidth(W), .pUfiAdrsWidth(A), .pUfiSlaveNum(N),
                     .pDecodeLsb(DL), .pDecodeWidth(DW), .pTimeoutCycles(TO)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .iSUfiWd(iSUfiWd), .iSUfiWAdrs(iSUfiWAdrs), .iSUfiWEd(iSUfiWEd),
    .iSUfiRAdrs(iSUfiRAdrs), .iSUfiREd(iSUfiREd),
    .oSUfiRdy(oSUfiRdy), .oSUfiRd(oSUfiRd), .oSUfiRVd(oSUfiRVd), .oSUfiErr(oSUfiErr),
    .oMUfiWd(oMUfiWd), .oMUfiWAdrs(oMUfiWAdrs), .oMUfiWEd(oMUfiWEd),
    .oMUfiRAdrs(oMUfiRAdrs), .oMUfiREd(oMUfiREd),
    .iMUfiRd(iMUfiRd), .iMUfiRVd(iMUfiRVd));

  typedef struct { logic [A-1:0] adrs; logic [W-1:0] wd; logic we; logic [N-1:0] exp_wed; } wr_vec_t;
  typedef struct { logic [A-1:0] adrs; int lat; logic [W-1:0] exp_rd; logic exp_err; logic [N-1:0] exp_red; } rd_vec_t;
  typedef struct { logic [W-1:0] rd; logic err; int due; } exp_t;
  typedef struct { int slv; int fire; } pend_t;

  exp_t         sb[$];
  pend_t        pend[$];
  int           checks = 0, errors = 0, ncyc = 0;
  int           lat[N];
  logic [N-1:0] silent = '0, noise = '0;
  wr_vec_t      wtab[6];
  rd_vec_t      rtab[6];

  function automatic logic [W-1:0] sdat(int n);
    return (n == 2) ? 32'h1234_5678 : 32'hA0A0_0000 + W'(n);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  // One cycle: score any read beat, then advance the slave model.
  task automatic tick();
    exp_t e;
    @(negedge iCLK);
    ncyc++;
    if (iRST && oSUfiRVd) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rvd: got rd=%0h err=%0b at cycle %0d, expected no beat", oSUfiRd, oSUfiErr, ncyc);
      end else begin
        e = sb.pop_front();
        chk("rd_data", oSUfiRd, e.rd);
        chk("rd_err", oSUfiErr, e.err);
        chk("rd_latency", 64'(ncyc), 64'(e.due));
      end
    end
    for (int n = 0; n < N; n++)
      if (oMUfiREd[n] && !silent[n]) pend.push_back('{slv: n, fire: ncyc + lat[n]});
    iMUfiRVd = noise;
    for (int i = pend.size() - 1; i >= 0; i--)
      if (pend[i].fire == ncyc) begin
        iMUfiRVd = iMUfiRVd | (N'(1) << pend[i].slv);
        pend.delete(i);
      end
  endtask

  task automatic wait_rdy();
    int b = 0;
    while (!oSUfiRdy && b < 100) begin tick(); b++; end
    chk("wait_rdy", 64'(oSUfiRdy), 64'(1));
  endtask

  task automatic drain();
    int b = 0;
    while (sb.size() != 0 && b < 100) begin tick(); b++; end
    chk("sb_drain", 64'(sb.size()), 64'(0));
    sb.delete();
  endtask

  task automatic do_read(rd_vec_t v);
    int sl;
    wait_rdy();
    sl = int'(v.adrs[DL +: DW]);
    if (sl < N) lat[sl] = v.lat;
    iSUfiREd = 1'b1; iSUfiRAdrs = v.adrs;
    sb.push_back('{rd: v.exp_rd, err: v.exp_err, due: ncyc + (v.exp_err ? 1 : v.lat + 2)});
    tick();
    iSUfiREd = 1'b0;
    chk("rd_strobe", oMUfiREd, v.exp_red);
    if (!v.exp_err) chk("rd_adrs", oMUfiRAdrs, v.adrs);
    chk("rdy_busy", 64'(oSUfiRdy), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    wtab[0] = '{32'h3000_0010, 32'hA5A5_A5A5, 1'b1, 9'b000001000};
    wtab[1] = '{32'hF000_0000, 32'h1234_0000, 1'b1, 9'b000000000};
    wtab[2] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 9'b000000001};
    wtab[3] = '{32'h8FFF_FFFC, 32'hDEAD_BEEF, 1'b1, 9'b100000000};
    wtab[4] = '{32'h9000_0000, 32'h5555_AAAA, 1'b1, 9'b000000000};
    wtab[5] = '{32'h1000_0000, 32'h0F0F_0F0F, 1'b0, 9'b000000000};
    rtab[0] = '{32'h2000_0004, 3, 32'h1234_5678, 1'b0, 9'b000000100};
    rtab[1] = '{32'hC000_0000, 0, 32'h0,         1'b1, 9'b000000000};
    rtab[2] = '{32'h0000_0100, 0, sdat(0),       1'b0, 9'b000000001};
    rtab[3] = '{32'h8000_0040, 1, sdat(8),       1'b0, 9'b100000000};
    rtab[4] = '{32'h9000_0000, 0, 32'h0,         1'b1, 9'b000000000};
    rtab[5] = '{32'h5000_0000, 7, sdat(5),       1'b0, 9'b000100000};
    for (int n = 0; n < N; n++) begin
      iMUfiRd[n*W +: W] = sdat(n);
      lat[n] = 0;
    end

    tick(); tick();
    chk("rst_rdy", 64'(oSUfiRdy), 64'(1));
    chk("rst_rvd", 64'(oSUfiRVd), 64'(0));
    chk("rst_err", 64'(oSUfiErr), 64'(0));
    chk("rst_rd", oSUfiRd, 0);
    chk("rst_wed", oMUfiWEd, 0);
    chk("rst_red", oMUfiREd, 0);
    chk("rst_wadrs", oMUfiWAdrs, 0);
    iRST = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      iSUfiWEd = wtab[i].we; iSUfiWAdrs = wtab[i].adrs; iSUfiWd = wtab[i].wd;
      tick();
      chk("wr_wed", oMUfiWEd, wtab[i].exp_wed);
      chk("wr_adrs", oMUfiWAdrs, wtab[i].adrs);
      chk("wr_data", oMUfiWd, wtab[i].wd);
    end
    iSUfiWEd = 1'b0;

    for (int i = 0; i < 6; i++) begin
      do_read(rtab[i]);
      drain();
    end
    tick(); tick();
    chk("rd_hold", oSUfiRd, sdat(5));

    // Foreign valids and a second request during WAIT must both be ignored.
    do_read(rtab[0]);
    noise = 9'h1FB; iSUfiREd = 1'b1; iSUfiRAdrs = 32'hC000_0000;
    tick();
    chk("rdy_in_wait", 64'(oSUfiRdy), 64'(0));
    noise = '0; iSUfiREd = 1'b0;
    drain();

    // Same-cycle write and read to one slave are both issued.
    wait_rdy();
    lat[3] = 2;
    iSUfiWEd = 1'b1; iSUfiWAdrs = 32'h3000_0000; iSUfiWd = 32'hCAFE_F00D;
    iSUfiREd = 1'b1; iSUfiRAdrs = 32'h3000_0008;
    sb.push_back('{rd: sdat(3), err: 1'b0, due: ncyc + 4});
    tick();
    iSUfiWEd = 1'b0; iSUfiREd = 1'b0;
    chk("wr_rd_wed", oMUfiWEd, 9'b000001000);
    chk("wr_rd_red", oMUfiREd, 9'b000001000);
    drain();

    // Silent slave: timeout error beat, or indefinite WAIT until reset.
    silent[4] = 1'b1;
    wait_rdy();
    iSUfiREd = 1'b1; iSUfiRAdrs = 32'h4000_0000;
`ifdef UFI_ROUTER_TIMEOUT_EN
    sb.push_back('{rd: 32'h0, err: 1'b1, due: ncyc + TO + 1});
    tick();
    iSUfiREd = 1'b0;
    drain();
`else
    tick();
    iSUfiREd = 1'b0;
    repeat (20) tick();
    chk("stuck_rdy", 64'(oSUfiRdy), 64'(0));
    iRST = 1'b0;
    #1;
    chk("stuck_rst_rdy", 64'(oSUfiRdy), 64'(1));
    tick();
    iRST = 1'b1;
`endif
    silent[4] = 1'b0;

    // Reset mid-WAIT aborts; the late slave valid lands in IDLE.
    wait_rdy();
    lat[6] = 6;
    iSUfiREd = 1'b1; iSUfiRAdrs = 32'h6000_0000;
    tick();
    iSUfiREd = 1'b0;
    tick();
    iRST = 1'b0;
    #1;
    chk("abort_rdy", 64'(oSUfiRdy), 64'(1));
    chk("abort_rvd", 64'(oSUfiRVd), 64'(0));
    chk("abort_rd", oSUfiRd, 0);
    tick();
    iRST = 1'b1;
    repeat (8) tick();
    chk("late_vld_rdy", 64'(oSUfiRdy), 64'(1));
    chk("late_vld_pend", 64'(pend.size()), 64'(0));

    do_read('{32'h6000_0000, 1, sdat(6), 1'b0, 9'b001000000});
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
